hidden_delta_calc: RTL and testbench

Backprop stage for the 10-5-3 drowsiness network. It consumes the output-layer deltas (delta1) and the hidden-to-output weights (weight1), and produces the hidden-layer deltas (delta0) that the hidden-layer weight update uses. It performs one shared signed multiply-accumulate per cycle under a small FSM. The result is delta0[j] = sat(sum_k delta1[k]*w1_k[j]) * h_j*(1-h_j).

---
 rtl/hidden_delta_calc.sv | 251 +++++++++++++++++++++++++
 tb/tb_hidden_delta_calc.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hidden_delta_calc.sv
// -----------------------------------------------------------------------------
// hidden_delta_calc
//
// Backprop stage of the 10-5-3 drowsiness network. Computes the hidden-layer
// deltas from the output-layer deltas and the hidden-to-output weights:
//
//    delta0[j] = sat(sum_k delta1[k] * w1_k[j] >>> FRAC) * h_j*(1-h_j)
//
// using a single shared signed multiply-accumulate, one product per cycle.
// All data is two's-complement Q1.FRAC in W bits.
//
// Ports:
//    clk_i        system clock, rising edge
//    rst_ni       asynchronous active-low reset
//    start_i      one-cycle request, accepted only when not running
//    delta1_i     output-layer deltas, element k at [k*W +: W]
//    weight1_i    hidden-to-output weights, w1_k[j] at [(k*N_HID+j)*W +: W]
//    out_cal_i    hidden-layer outputs h_j, element j at [j*W +: W]
//    delta0_o     hidden-layer deltas, element j at [j*W +: W]
//    busy_o       high while a computation is in progress
//    done_o       one-cycle pulse, delta0_o complete and consistent
//    err_sat_o    sticky: an accumulator clipped during the current run
// -----------------------------------------------------------------------------
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for start_i; delta0_o and err_sat_o hold
// MAC   | accumulate delta1[k]*w1_k[j], one k per edge
// SCALE | saturate acc, apply sigmoid derivative, write delta0[j]
// DONE  | done_o pulse for one cycle; start_i sampled on the exit edge
//
module hidden_delta_calc #(
   parameter int N_OUT = 3,
   parameter int N_HID = 5,
   parameter int W     = 10,
   parameter int FRAC  = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic [N_OUT*W-1:0]       delta1_i,
   input  logic [N_OUT*N_HID*W-1:0] weight1_i,
   input  logic [N_HID*W-1:0]       out_cal_i,
   output logic [N_HID*W-1:0]       delta0_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_sat_o
);

   localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int JW = (N_HID > 1) ? $clog2(N_HID) : 1;
   localparam int PW = 2 * W;
   // Enough headroom that summing N_OUT full-scale products cannot wrap.
   localparam int AW = PW + $clog2(N_OUT + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_MAC   = 2'd1;
   localparam logic [1:0] S_SCALE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);
   localparam logic [JW-1:0] J_LAST = JW'(N_HID - 1);

   localparam logic signed [AW-1:0] A_MAX = AW'((1 << (W - 1)) - 1);
   localparam logic signed [AW-1:0] A_MIN = ~A_MAX;

   localparam logic [FRAC:0] ONE = (FRAC + 1)'(1 << FRAC);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]                     state_q, state_d;
   logic [N_OUT*W-1:0]             d1_q, d1_d;
   logic [N_OUT*N_HID*W-1:0]       w1_q, w1_d;
   logic [N_HID*W-1:0]             h_q, h_d;
   logic signed [AW-1:0]           acc_q, acc_d;
   logic [KW-1:0]                  k_q, k_d;
   logic [JW-1:0]                  j_q, j_d;
   logic [N_HID*W-1:0]             delta0_q, delta0_d;
   logic                           busy_q, busy_d;
   logic                           done_q, done_d;
   logic                           err_q, err_d;

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   logic signed [W-1:0]            d1_sel;
   logic signed [W-1:0]            w1_sel;
   logic signed [W-1:0]            h_sel;
   logic signed [PW-1:0]           prod;
   logic signed [AW-1:0]           acc_sum;
   logic signed [AW-1:0]           acc_sh;
   logic signed [W-1:0]            a_sat;
   logic                           a_clip;
   logic [FRAC-1:0]                hc;
   logic [FRAC:0]                  one_minus_h;
   logic [2*FRAC+1:0]              sp_full;
   logic [FRAC:0]                  sp;
   logic signed [W+FRAC+1:0]       d_prod;
   logic [W-1:0]                   d_new;
   logic                           start_ok;

   assign d1_sel = d1_q[k_q*W +: W];
   assign w1_sel = w1_q[(k_q*N_HID + j_q)*W +: W];
   assign h_sel  = h_q[j_q*W +: W];

   assign prod    = d1_sel * w1_sel;
   assign acc_sum = acc_q + {{(AW - PW){prod[PW-1]}}, prod};

   assign acc_sh = acc_q >>> FRAC;

   always_comb begin
      a_clip = 1'b0;
      a_sat  = acc_sh[W-1:0];
      if (acc_sh > A_MAX) begin
         a_clip = 1'b1;
         a_sat  = A_MAX[W-1:0];
      end else if (acc_sh < A_MIN) begin
         a_clip = 1'b1;
         a_sat  = A_MIN[W-1:0];
      end
   end

   // Sigmoid outputs outside [0, 1) are treated as the nearest valid value,
   // so the derivative term never goes negative.
   always_comb begin
      hc = h_sel[FRAC-1:0];
      if (h_sel[W-1]) begin
         hc = '0;
      end else if (|h_sel[W-2:FRAC]) begin
         hc = '1;
      end
   end

   assign one_minus_h = ONE - {1'b0, hc};
   assign sp_full     = {1'b0, hc} * {1'b0, one_minus_h};
   assign sp          = sp_full[FRAC +: FRAC + 1];

   assign d_prod = a_sat * $signed({1'b0, sp});
   // Arithmetic shift by FRAC; the result is bounded to W bits, so taking the
   // slice is the same as shifting then truncating.
   assign d_new  = d_prod[FRAC +: W];

   // A run may start from IDLE, or on the edge that leaves DONE, which gives
   // back-to-back runs every N_HID*(N_OUT+1)+1 cycles when start_i is held.
   assign start_ok = start_i && ((state_q == S_IDLE) || (state_q == S_DONE));

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      d1_d     = d1_q;
      w1_d     = w1_q;
      h_d      = h_q;
      acc_d    = acc_q;
      k_d      = k_q;
      j_d      = j_q;
      delta0_d = delta0_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = err_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
            if (start_ok) begin
               state_d = S_MAC;
               d1_d    = delta1_i;
               w1_d    = weight1_i;
               h_d     = out_cal_i;
               acc_d   = '0;
               k_d     = '0;
               j_d     = '0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end

         S_MAC: begin
            acc_d = acc_sum;
            if (k_q == K_LAST) begin
               state_d = S_SCALE;
            end else begin
               k_d = k_q + 1'b1;
            end
         end

         S_SCALE: begin
            delta0_d[j_q*W +: W] = d_new;
            if (a_clip) begin
               err_d = 1'b1;
            end
            acc_d = '0;
            k_d   = '0;
            if (j_q == J_LAST) begin
               state_d = S_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               j_d     = j_q + 1'b1;
               state_d = S_MAC;
            end
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         d1_q     <= '0;
         w1_q     <= '0;
         h_q      <= '0;
         acc_q    <= '0;
         k_q      <= '0;
         j_q      <= '0;
         delta0_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         d1_q     <= d1_d;
         w1_q     <= w1_d;
         h_q      <= h_d;
         acc_q    <= acc_d;
         k_q      <= k_d;
         j_q      <= j_d;
         delta0_q <= delta0_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign delta0_o  = delta0_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign err_sat_o = err_q;

endmodule

// File: tb/tb_hidden_delta_calc.sv
// -----------------------------------------------------------------------------
// Testbench for hidden_delta_calc. Stimulus pushes the hand-computed result of
// each accepted run into a queue; a monitor pops and compares on every done.
// -----------------------------------------------------------------------------
module tb_hidden_delta_calc;

   localparam int N_OUT = 3;
   localparam int N_HID = 5;
   localparam int W     = 10;

   typedef struct packed {
      logic [N_HID*W-1:0] d0;
      logic               es;
   } exp_t;

   logic                     clk_i = 1'b0;
   logic                     rst_ni = 1'b1;
   logic                     start_i = 1'b0;
   logic [N_OUT*W-1:0]       delta1_i = '0;
   logic [N_OUT*N_HID*W-1:0] weight1_i = '0;
   logic [N_HID*W-1:0]       out_cal_i = '0;
   logic [N_HID*W-1:0]       delta0_o;
   logic                     busy_o;
   logic                     done_o;
   logic                     err_sat_o;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   hidden_delta_calc #(.N_OUT(N_OUT), .N_HID(N_HID), .W(W), .FRAC(8)) dut (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .start_i   (start_i),
      .delta1_i  (delta1_i),
      .weight1_i (weight1_i),
      .out_cal_i (out_cal_i),
      .delta0_o  (delta0_o),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .err_sat_o (err_sat_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [N_OUT*W-1:0] pack3(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [W-1:0] c);
      return {c, b, a};
   endfunction

   function automatic logic [N_HID*W-1:0] pack5(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic [W-1:0] c, input logic [W-1:0] d,
                                                input logic [W-1:0] e);
      return {e, d, c, b, a};
   endfunction

   function automatic logic [N_HID*W-1:0] rep5(input logic [W-1:0] v);
      return {v, v, v, v, v};
   endfunction

   function automatic logic [N_OUT*N_HID*W-1:0] rep15(input logic [W-1:0] v);
      logic [N_OUT*N_HID*W-1:0] r;
      for (int i = 0; i < N_OUT * N_HID; i++) r[i*W +: W] = v;
      return r;
   endfunction

   // Monitor: compares every done pulse against the oldest expectation.
   always @(negedge clk_i) begin
      if (rst_ni && done_o) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done with empty scoreboard, expected none");
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            for (int j = 0; j < N_HID; j++)
               chk($sformatf("delta0[%0d]", j), 64'(delta0_o[j*W +: W]), 64'(e.d0[j*W +: W]));
            chk("err_sat_at_done", 64'(err_sat_o), 64'(e.es));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic load(input logic [N_OUT*W-1:0] d1, input logic [N_OUT*N_HID*W-1:0] w1,
                       input logic [N_HID*W-1:0] h);
      delta1_i  = d1;
      weight1_i = w1;
      out_cal_i = h;
   endtask

   // Issues Start so that it is sampled at "edge 0"; returns #1 after edge 0.
   task automatic start_run(input exp_t e);
      @(negedge clk_i);
      start_i = 1'b1;
      sb_q.push_back(e);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
   endtask

   // Counts edges after edge 'base' until done_o is seen; busy must stay high
   // on every earlier edge and be low together with done.
   task automatic wait_done(input int base, output int n, output bit busy_ok);
      n = -1;
      busy_ok = 1'b1;
      for (int i = base + 1; i <= base + 40; i++) begin
         @(posedge clk_i);
         #1;
         if (done_o) begin
            n = i;
            if (busy_o) busy_ok = 1'b0;
            break;
         end
         if (!busy_o) busy_ok = 1'b0;
      end
   endtask

   task automatic settle();
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   logic [N_OUT*W-1:0]       d1_t1;
   logic [N_OUT*N_HID*W-1:0] w1_t1;
   logic [N_HID*W-1:0]       h_t1;
   exp_t                     e_t1;

   initial begin
      int n;
      bit bok;
      exp_t e;

      d1_t1 = pack3(10'd256, 10'd0, 10'd0);
      w1_t1 = rep15(10'd128);
      h_t1  = rep5(10'd128);
      e_t1.d0 = rep5(10'd32);
      e_t1.es = 1'b0;

      // Reset
      #2 rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset_busy", 64'(busy_o), 64'd0);
      chk("reset_done", 64'(done_o), 64'd0);
      chk("reset_err_sat", 64'(err_sat_o), 64'd0);
      chk("reset_delta0", 64'(delta0_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // 1: basic run
      load(d1_t1, w1_t1, h_t1);
      start_run(e_t1);
      chk("t1_busy_after_start", 64'(busy_o), 64'd1);
      wait_done(0, n, bok);
      chk("t1_latency", 64'(n), 64'd20);
      chk("t1_busy_window", 64'(bok), 64'd1);
      settle();
      chk("t1_done_one_cycle", 64'(done_o), 64'd0);
      chk("t1_delta0_hold_idle", 64'(delta0_o), 64'(rep5(10'd32)));

      // 2: negative sign
      load(pack3(-10'sd256, 10'd0, 10'd0), w1_t1, h_t1);
      e.d0 = rep5(10'h3E0);
      e.es = 1'b0;
      start_run(e);
      wait_done(0, n, bok);
      chk("t2_latency", 64'(n), 64'd20);
      settle();

      // 3: saturation, then a clean run clears err_sat
      load(pack3(10'd511, 10'd511, 10'd511), rep15(10'd511), h_t1);
      e.d0 = rep5(10'd127);
      e.es = 1'b1;
      start_run(e);
      wait_done(0, n, bok);
      chk("t3_latency", 64'(n), 64'd20);
      settle();
      chk("t3_err_sat_hold", 64'(err_sat_o), 64'd1);
      load(d1_t1, w1_t1, h_t1);
      start_run(e_t1);
      chk("t3_err_sat_clear_on_start", 64'(err_sat_o), 64'd0);
      wait_done(0, n, bok);
      settle();

      // 4: sigmoid-prime clamp
      load(d1_t1, w1_t1, pack5(10'd0, 10'd255, 10'd300, -10'sd100, 10'd128));
      e.d0 = pack5(10'd0, 10'd0, 10'd0, 10'd0, 10'd32);
      e.es = 1'b0;
      start_run(e);
      wait_done(0, n, bok);
      chk("t4_latency", 64'(n), 64'd20);
      settle();

      // 5a: Start at edge 5 with different operands is ignored
      load(d1_t1, w1_t1, h_t1);
      start_run(e_t1);
      repeat (4) @(posedge clk_i);
      #1;
      start_i  = 1'b1;
      delta1_i = pack3(-10'sd256, 10'd100, 10'd50);
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      wait_done(5, n, bok);
      chk("t5_ignored_start_latency", 64'(n), 64'd20);
      chk("t5_ignored_start_busy", 64'(bok), 64'd1);
      settle();

      // 5b: Start held high gives back-to-back runs every 21 cycles
      load(d1_t1, w1_t1, h_t1);
      @(negedge clk_i);
      start_i = 1'b1;
      sb_q.push_back(e_t1);
      sb_q.push_back(e_t1);
      @(posedge clk_i);
      #1;
      wait_done(0, n, bok);
      chk("t5_held_first_done", 64'(n), 64'd20);
      wait_done(20, n, bok);
      chk("t5_held_second_done", 64'(n), 64'd41);
      chk("t5_held_busy", 64'(bok), 64'd1);
      start_i = 1'b0;
      settle();

      // 6: asynchronous reset mid-run (saturating data so err_sat is set)
      load(pack3(10'd511, 10'd511, 10'd511), rep15(10'd511), h_t1);
      e.d0 = rep5(10'd127);
      e.es = 1'b1;
      start_run(e);
      repeat (9) @(posedge clk_i);
      #2;
      chk("t6_err_sat_before_reset", 64'(err_sat_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      chk("t6_reset_busy", 64'(busy_o), 64'd0);
      chk("t6_reset_done", 64'(done_o), 64'd0);
      chk("t6_reset_err_sat", 64'(err_sat_o), 64'd0);
      chk("t6_reset_delta0", 64'(delta0_o), 64'd0);
      sb_q.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      load(d1_t1, w1_t1, h_t1);
      start_run(e_t1);
      wait_done(0, n, bok);
      chk("t6_latency_after_reset", 64'(n), 64'd20);
      settle();

      chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
